// File: rtl/vram_pkg.sv
// vram_pkg: shared types and default geometry for the video-RAM write path.
//   vram_ctrl_state_t : write-controller FSM states
//   DISPLAY_*_DEF     : default panel geometry
//   vram_addr_t       : row-major VRAM address for the default geometry
package vram_pkg;

   localparam int unsigned DISPLAY_WIDTH_DEF  = 240;
   localparam int unsigned DISPLAY_HEIGHT_DEF = 320;
   localparam int unsigned PIXEL_W            = 16;
   localparam int unsigned TOUCH_W            = 9;
   // Signed width for centre+offset arithmetic; covers negative offsets.
   localparam int unsigned COORD_W            = 11;
   localparam int unsigned VRAM_AW            = $clog2(DISPLAY_WIDTH_DEF * DISPLAY_HEIGHT_DEF);

   typedef logic [VRAM_AW-1:0] vram_addr_t;

   typedef enum logic [1:0] {
      S_CLEAR,
      S_IDLE,
      S_DRAW
   } vram_ctrl_state_t;

endpackage

// File: rtl/vram_write_controller_if.sv
// vram_write_controller_if: touch/clear requests in, VRAM write port and status out.
//   master : request side (touch source / testbench)
//   slave  : vram_write_controller
interface vram_write_controller_if
   import vram_pkg::*;
#(
   parameter int unsigned VRAM_W = PIXEL_W,
   parameter int unsigned AW     = VRAM_AW
);
   logic               clear_req;
   logic               touch_valid;
   logic [TOUCH_W-1:0] touch_x;
   logic [TOUCH_W-1:0] touch_y;
   logic [VRAM_W-1:0]  color;
   logic               vram_wr_ena;
   logic [AW-1:0]      vram_wr_addr;
   logic [VRAM_W-1:0]  vram_wr_data;
   logic               busy;
   logic               clear_done;

   modport master (
      output clear_req, touch_valid, touch_x, touch_y, color,
      input  vram_wr_ena, vram_wr_addr, vram_wr_data, busy, clear_done
   );

   modport slave (
      input  clear_req, touch_valid, touch_x, touch_y, color,
      output vram_wr_ena, vram_wr_addr, vram_wr_data, busy, clear_done
   );
endinterface

// File: rtl/vram_write_controller_brush_stepper.sv
// brush_stepper: walks a BRUSH x BRUSH square around (cx, cy), row by row.
//   clk, rst  : clock, synchronous active-low reset
//   ena       : advance enable for the offset counters
//   start     : return counters to the first offset and clear done
//   step      : advance to the next offset (wraps to the first after the last)
//   cx, cy    : brush centre
//   in_bounds_c, addr_c, last_c : current pixel on-screen flag, row-major address, last-offset flag
//   done      : registered, set by the step that consumed the last offset
module brush_stepper
   import vram_pkg::*;
#(
   parameter int unsigned DISPLAY_WIDTH  = DISPLAY_WIDTH_DEF,
   parameter int unsigned DISPLAY_HEIGHT = DISPLAY_HEIGHT_DEF,
   parameter int unsigned BRUSH          = 3,
   parameter int unsigned AW             = VRAM_AW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ena,
   input  logic               start,
   input  logic               step,
   input  logic [TOUCH_W-1:0] cx,
   input  logic [TOUCH_W-1:0] cy,
   output logic               in_bounds_c,
   output logic [AW-1:0]      addr_c,
   output logic               last_c,
   output logic               done
);

   localparam int unsigned R  = (BRUSH - 1) / 2;
   localparam int unsigned CW = (BRUSH > 1) ? $clog2(BRUSH) : 1;

   localparam logic signed [COORD_W-1:0] W_S = COORD_W'(DISPLAY_WIDTH);
   localparam logic signed [COORD_W-1:0] H_S = COORD_W'(DISPLAY_HEIGHT);
   localparam logic signed [COORD_W-1:0] R_S = COORD_W'(R);
   localparam logic [CW-1:0]             IDX_MAX = CW'(BRUSH - 1);

   logic [CW-1:0]               ix;
   logic [CW-1:0]               iy;
   logic signed [COORD_W-1:0]   px;
   logic signed [COORD_W-1:0]   py;

   // Counter index 0..BRUSH-1 maps to offset -R..R.
   assign px = $signed(COORD_W'(cx)) + $signed(COORD_W'(ix)) - R_S;
   assign py = $signed(COORD_W'(cy)) + $signed(COORD_W'(iy)) - R_S;

   assign in_bounds_c = !px[COORD_W-1] && (px < W_S) && !py[COORD_W-1] && (py < H_S);
   // Off-screen pixels produce a wrapped address; the caller never writes them.
   assign addr_c      = AW'(py) * AW'(DISPLAY_WIDTH) + AW'(px);
   assign last_c      = (ix == IDX_MAX) && (iy == IDX_MAX);

   // dx is the inner loop, dy the outer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ix   <= '0;
         iy   <= '0;
         done <= 1'b0;
      end else if (ena) begin
         if (start) begin
            ix   <= '0;
            iy   <= '0;
            done <= 1'b0;
         end else if (step) begin
            done <= last_c;
            if (last_c) begin
               ix <= '0;
               iy <= '0;
            end else if (ix == IDX_MAX) begin
               ix <= '0;
               iy <= iy + CW'(1);
            end else begin
               ix <= ix + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/vram_write_controller.sv
// vram_write_controller: owns the VRAM write port; clears to BG_COLOR on reset or
// request and paints a clipped square brush at each new touch sample.
//   clk, rst : clock, synchronous active-low reset
//   ena      : advance enable; low freezes all state and suppresses writes
//   bus      : touch/clear requests in; vram_wr_*, busy, clear_done out (all registered)
module vram_write_controller
   import vram_pkg::*;
#(
   parameter int unsigned       DISPLAY_WIDTH  = DISPLAY_WIDTH_DEF,
   parameter int unsigned       DISPLAY_HEIGHT = DISPLAY_HEIGHT_DEF,
   parameter int unsigned       VRAM_W         = PIXEL_W,
   parameter int unsigned       BRUSH          = 3,
   parameter logic [VRAM_W-1:0] BG_COLOR       = VRAM_W'(16'hFFFF)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ena,
   vram_write_controller_if.slave  bus
);

   localparam int unsigned L    = DISPLAY_WIDTH * DISPLAY_HEIGHT;
   localparam int unsigned AW   = $clog2(L);
   localparam int unsigned CNTW = $clog2(L + 1);

   vram_ctrl_state_t state;
   vram_ctrl_state_t state_nxt;

   logic [CNTW-1:0]    cnt;
   logic [CNTW-1:0]    cnt_d;
   logic [TOUCH_W-1:0] pt_x;
   logic [TOUCH_W-1:0] pt_y;
   logic [VRAM_W-1:0]  pt_color;
   logic [TOUCH_W-1:0] last_x;
   logic [TOUCH_W-1:0] last_y;
   logic [VRAM_W-1:0]  last_color;
   logic               last_valid;

   logic               wr_ena_q;
   logic [AW-1:0]      addr_q;
   logic [VRAM_W-1:0]  data_q;
   logic               busy_q;
   logic               done_q;

   logic               wr_ena_d;
   logic [AW-1:0]      addr_d;
   logic [VRAM_W-1:0]  data_d;
   logic               busy_d;
   logic               done_d;
   logic               step_c;
   logic               start_c;
   logic               latch_c;
   logic               commit_c;
   logic               inval_c;

   logic               touch_ok_c;
   logic               same_c;
   logic               accept_c;
   logic               clear_end_c;
   logic [TOUCH_W-1:0] cx_c;
   logic [TOUCH_W-1:0] cy_c;
   logic               st_in_bounds_c;
   logic [AW-1:0]      st_addr_c;
   logic               st_last_c;
   logic               st_done;

   assign touch_ok_c  = bus.touch_valid
                        && (32'(bus.touch_x) < DISPLAY_WIDTH)
                        && (32'(bus.touch_y) < DISPLAY_HEIGHT);
   assign same_c      = last_valid && (bus.touch_x == last_x) && (bus.touch_y == last_y)
                        && (bus.color == last_color);
   assign accept_c    = touch_ok_c && !same_c;
   assign clear_end_c = (cnt == CNTW'(L));

   // The first brush pixel is issued on the accept edge, so the stepper sees the raw touch in idle.
   assign cx_c = (state == S_IDLE) ? bus.touch_x : pt_x;
   assign cy_c = (state == S_IDLE) ? bus.touch_y : pt_y;

   brush_stepper #(
      .DISPLAY_WIDTH  (DISPLAY_WIDTH),
      .DISPLAY_HEIGHT (DISPLAY_HEIGHT),
      .BRUSH          (BRUSH),
      .AW             (AW)
   ) u_stepper (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .start       (start_c),
      .step        (step_c),
      .cx          (cx_c),
      .cy          (cy_c),
      .in_bounds_c (st_in_bounds_c),
      .addr_c      (st_addr_c),
      .last_c      (st_last_c),
      .done        (st_done)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_CLEAR;
      end else if (ena) begin
         state <= state_nxt;
      end
   end

   // Next-state logic; clear requests win over touches and abort a brush.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_CLEAR: if (clear_end_c) state_nxt = S_IDLE;
         S_IDLE: begin
            if (bus.clear_req)  state_nxt = S_CLEAR;
            else if (accept_c)  state_nxt = S_DRAW;
         end
         S_DRAW: begin
            if (bus.clear_req)  state_nxt = S_CLEAR;
            else if (st_done)   state_nxt = S_IDLE;
         end
         default: state_nxt = S_CLEAR;
      endcase
   end

   // Output and datapath control; a clear started from idle/draw issues address 0 immediately.
   always_comb begin
      wr_ena_d = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;
      done_d   = 1'b0;
      cnt_d    = cnt;
      step_c   = 1'b0;
      start_c  = 1'b0;
      latch_c  = 1'b0;
      commit_c = 1'b0;
      inval_c  = 1'b0;
      unique case (state)
         S_CLEAR: begin
            if (clear_end_c) begin
               done_d  = 1'b1;
               inval_c = 1'b1;
               cnt_d   = '0;
            end else begin
               wr_ena_d = 1'b1;
               addr_d   = AW'(cnt);
               data_d   = BG_COLOR;
               cnt_d    = cnt + CNTW'(1);
            end
         end
         S_IDLE: begin
            if (bus.clear_req) begin
               wr_ena_d = 1'b1;
               addr_d   = '0;
               data_d   = BG_COLOR;
               cnt_d    = CNTW'(1);
            end else if (accept_c) begin
               wr_ena_d = st_in_bounds_c;
               addr_d   = st_addr_c;
               data_d   = bus.color;
               step_c   = 1'b1;
               latch_c  = 1'b1;
            end
         end
         S_DRAW: begin
            if (bus.clear_req) begin
               wr_ena_d = 1'b1;
               addr_d   = '0;
               data_d   = BG_COLOR;
               cnt_d    = CNTW'(1);
               start_c  = 1'b1;
            end else if (st_done) begin
               commit_c = 1'b1;
            end else begin
               wr_ena_d = st_in_bounds_c;
               addr_d   = st_addr_c;
               data_d   = pt_color;
               step_c   = 1'b1;
            end
         end
         default: ;
      endcase
      busy_d = (state_nxt != S_IDLE);
   end

   // Output registers, clear counter, latched and last-drawn points.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ena_q   <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cnt        <= '0;
         pt_x       <= '0;
         pt_y       <= '0;
         pt_color   <= '0;
         last_x     <= '0;
         last_y     <= '0;
         last_color <= '0;
         last_valid <= 1'b0;
      end else if (!ena) begin
         wr_ena_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         wr_ena_q <= wr_ena_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cnt      <= cnt_d;
         if (latch_c) begin
            pt_x     <= bus.touch_x;
            pt_y     <= bus.touch_y;
            pt_color <= bus.color;
         end
         if (commit_c) begin
            last_x     <= pt_x;
            last_y     <= pt_y;
            last_color <= pt_color;
            last_valid <= 1'b1;
         end else if (inval_c) begin
            last_valid <= 1'b0;
         end
      end
   end

   assign bus.vram_wr_ena  = wr_ena_q;
   assign bus.vram_wr_addr = addr_q;
   assign bus.vram_wr_data = data_q;
   assign bus.busy         = busy_q;
   assign bus.clear_done   = done_q;

endmodule

// File: tb/tb_vram_write_controller.sv
// tb_vram_write_controller: directed bench. A full-size instance covers the reset
// clear and brush addressing; a 16x12 instance covers the remaining clear scenarios.
module tb_vram_write_controller;
   import vram_pkg::*;

   localparam int unsigned L_A = 240 * 320;
   localparam int unsigned SW  = 16;
   localparam int unsigned SH  = 12;
   localparam int unsigned L_B = SW * SH;

   logic        clk = 1'b0;
   logic        rst_a, rst_b, ena_a, ena_b, sel;
   logic        tv, creq;
   logic [8:0]  tx, ty;
   logic [15:0] tc;

   int          checks;
   int          errors;
   int          ndone;
   logic [16:0] wa[$];
   logic [15:0] wd[$];

   always #5 clk = ~clk;

   vram_write_controller_if #(.VRAM_W(16), .AW(17)) bus_a ();
   vram_write_controller_if #(.VRAM_W(16), .AW(8))  bus_b ();

   assign bus_a.clear_req   = creq & ~sel;
   assign bus_a.touch_valid = tv & ~sel;
   assign bus_a.touch_x     = tx;
   assign bus_a.touch_y     = ty;
   assign bus_a.color       = tc;
   assign bus_b.clear_req   = creq & sel;
   assign bus_b.touch_valid = tv & sel;
   assign bus_b.touch_x     = tx;
   assign bus_b.touch_y     = ty;
   assign bus_b.color       = tc;

   vram_write_controller u_dut_a (
      .clk (clk),
      .rst (rst_a),
      .ena (ena_a),
      .bus (bus_a)
   );

   vram_write_controller #(
      .DISPLAY_WIDTH  (SW),
      .DISPLAY_HEIGHT (SH)
   ) u_dut_b (
      .clk (clk),
      .rst (rst_b),
      .ena (ena_b),
      .bus (bus_b)
   );

   logic        s_wr_ena, s_busy, s_done;
   logic [16:0] s_addr;
   logic [15:0] s_data;

   assign s_wr_ena = sel ? bus_b.vram_wr_ena : bus_a.vram_wr_ena;
   assign s_addr   = sel ? 17'(bus_b.vram_wr_addr) : bus_a.vram_wr_addr;
   assign s_data   = sel ? bus_b.vram_wr_data : bus_a.vram_wr_data;
   assign s_busy   = sel ? bus_b.busy : bus_a.busy;
   assign s_done   = sel ? bus_b.clear_done : bus_a.clear_done;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr_log();
      wa.delete();
      wd.delete();
      ndone = 0;
   endtask

   task automatic touch(input int x, input int y, input logic [15:0] c);
      tv = 1'b1;
      tx = 9'(x);
      ty = 9'(y);
      tc = c;
   endtask

   // Advance n cycles, logging writes and done pulses; request inputs last one cycle.
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (s_wr_ena) begin
            wa.push_back(s_addr);
            wd.push_back(s_data);
         end
         if (s_done) ndone++;
         tv   = 1'b0;
         creq = 1'b0;
      end
   endtask

   task automatic check_brush(input string tag, input int n, input int e [9], input logic [15:0] c);
      int bad;
      bad = 0;
      check({tag, "_count"}, wa.size(), n);
      if (wa.size() == n) begin
         for (int i = 0; i < n; i++) check({tag, "_addr"}, wa[i], e[i]);
      end
      for (int i = 0; i < wa.size(); i++) if (wd[i] !== c) bad++;
      check({tag, "_data"}, bad, 0);
   endtask

   task automatic check_clear(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < wa.size(); i++) begin
         if (wa[i] !== 17'(i) || wd[i] !== 16'hFFFF) bad++;
      end
      check({tag, "_count"}, wa.size(), L_B);
      check({tag, "_order"}, bad, 0);
      check({tag, "_done"}, ndone, 1);
   endtask

   initial begin
      int bad;
      checks = 0;
      errors = 0;
      rst_a = 1'b0; rst_b = 1'b0; ena_a = 1'b1; ena_b = 1'b1; sel = 1'b0;
      tv = 1'b0; creq = 1'b0; tx = '0; ty = '0; tc = '0;
      clr_log();

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_wr_ena", s_wr_ena, 0);
      check("rst_addr", s_addr, 0);
      check("rst_data", s_data, 0);
      check("rst_busy", s_busy, 0);
      check("rst_done", s_done, 0);

      // Power-up clear: one BG write per cycle over the whole frame
      rst_a = 1'b1;
      rst_b = 1'b1;
      bad = 0;
      for (int i = 0; i < L_A; i++) begin
         @(negedge clk);
         if (!(s_wr_ena === 1'b1 && s_addr === 17'(i) && s_data === 16'hFFFF
               && s_busy === 1'b1 && s_done === 1'b0)) bad++;
      end
      check("clear_seq", bad, 0);
      @(negedge clk);
      check("clear_done", s_done, 1);
      check("clear_busy_fall", s_busy, 0);
      check("clear_end_wr", s_wr_ena, 0);
      @(negedge clk);
      check("done_one_cycle", s_done, 0);

      // Interior brush; a touch during the trailing cycle is dropped
      clr_log();
      touch(10, 20, 16'hF800);
      cyc(9);
      check("draw_busy", s_busy, 1);
      check_brush("brush_mid", 9, '{4569, 4570, 4571, 4809, 4810, 4811, 5049, 5050, 5051}, 16'hF800);
      touch(50, 50, 16'h07E0);
      cyc(1);
      check("draw_tail_busy", s_busy, 0);
      check("draw_tail_wr", s_wr_ena, 0);

      // Corner brushes, touch issued on the first idle cycle
      clr_log();
      touch(0, 0, 16'h001F);
      cyc(10);
      check_brush("brush_tl", 4, '{0, 1, 240, 241, 0, 0, 0, 0, 0}, 16'h001F);
      clr_log();
      touch(239, 319, 16'h07E0);
      cyc(10);
      check_brush("brush_br", 4, '{76558, 76559, 76798, 76799, 0, 0, 0, 0, 0}, 16'h07E0);

      // Repeat suppression and out-of-range drops
      clr_log();
      touch(10, 20, 16'hF800);
      cyc(10);
      check("redraw_count", wa.size(), 9);
      clr_log();
      touch(10, 20, 16'hF800);
      cyc(10);
      check("repeat_skip", wa.size(), 0);
      check("repeat_busy", s_busy, 0);
      touch(240, 5, 16'h1111);
      cyc(10);
      check("x_oob_skip", wa.size(), 0);
      touch(5, 320, 16'h2222);
      cyc(10);
      check("y_oob_skip", wa.size(), 0);

      // Small display: repeat skipped until a clear invalidates the last point
      sel = 1'b1;
      clr_log();
      touch(5, 4, 16'hF800);
      cyc(10);
      check_brush("small_brush", 9, '{52, 53, 54, 68, 69, 70, 84, 85, 86}, 16'hF800);
      clr_log();
      touch(5, 4, 16'hF800);
      cyc(10);
      check("small_repeat_skip", wa.size(), 0);
      clr_log();
      creq = 1'b1;
      cyc(L_B + 1);
      check_clear("req_clear");
      clr_log();
      touch(5, 4, 16'hF800);
      cyc(10);
      check("after_clear_redraw", wa.size(), 9);

      // Clear request on the 4th brush cycle aborts the brush
      clr_log();
      touch(8, 8, 16'h1234);
      cyc(4);
      check("abort_pre_count", wa.size(), 4);
      if (wa.size() == 4) check("abort_4th_addr", wa[3], 135);
      clr_log();
      creq = 1'b1;
      cyc(1);
      check("abort_wr", s_wr_ena, 1);
      check("abort_addr", s_addr, 0);
      check("abort_data", s_data, 16'hFFFF);
      cyc(L_B);
      check_clear("abort_clear");

      // Clear beats a simultaneous touch
      clr_log();
      creq = 1'b1;
      touch(3, 3, 16'h0F0F);
      cyc(1);
      check("prio_addr", s_addr, 0);
      check("prio_data", s_data, 16'hFFFF);
      cyc(L_B);
      check_clear("prio_clear");

      // Mid-clear: re-request ignored, ena low freezes the sweep
      clr_log();
      creq = 1'b1;
      cyc(50);
      creq = 1'b1;
      cyc(50);
      ena_b = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc(1);
         check("ena_hold_wr", s_wr_ena, 0);
         check("ena_hold_addr", s_addr, 99);
      end
      ena_b = 1'b1;
      cyc(L_B - 100 + 1);
      check_clear("ena_clear");

      // Reset mid-draw, then clear restarts from address 0
      clr_log();
      touch(8, 8, 16'h1234);
      cyc(3);
      rst_b = 1'b0;
      cyc(1);
      check("mid_rst_wr", s_wr_ena, 0);
      check("mid_rst_addr", s_addr, 0);
      check("mid_rst_data", s_data, 0);
      check("mid_rst_busy", s_busy, 0);
      cyc(2);
      rst_b = 1'b1;
      clr_log();
      cyc(L_B + 1);
      check_clear("rst_clear");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
